// File: rtl/msrv32_trap_pkg.sv
// Shared encodings for the msrv32 machine-mode trap sequencer: FSM states, PC mux selects, cause codes, SYSTEM decode patterns.
// MSRV32_TRAP_WFI_EN adds the WFI_SLEEP state.
package msrv32_trap_pkg;

`ifdef MSRV32_TRAP_WFI_EN
  typedef enum logic [4:0] {
    RESET       = 5'b00001,
    OPERATING   = 5'b00010,
    TRAP_TAKEN  = 5'b00100,
    TRAP_RETURN = 5'b01000,
    WFI_SLEEP   = 5'b10000
  } state_t;
`else
  typedef enum logic [3:0] {
    RESET       = 4'b0001,
    OPERATING   = 4'b0010,
    TRAP_TAKEN  = 4'b0100,
    TRAP_RETURN = 4'b1000
  } state_t;
`endif

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_EPC  = 2'b01;
  localparam logic [1:0] PC_TRAP = 2'b10;
  localparam logic [1:0] PC_NEXT = 2'b11;

  localparam logic [3:0] CAUSE_M_EXT_IRQ      = 4'b1011;
  localparam logic [3:0] CAUSE_M_SW_IRQ       = 4'b0011;
  localparam logic [3:0] CAUSE_M_TIMER_IRQ    = 4'b0111;
  localparam logic [3:0] CAUSE_ILLEGAL_INSTR  = 4'b0010;
  localparam logic [3:0] CAUSE_INSTR_MISALIGN = 4'b0000;
  localparam logic [3:0] CAUSE_ECALL_M        = 4'b1011;
  localparam logic [3:0] CAUSE_BREAKPOINT     = 4'b0011;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'b0110;
  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'b0100;

  localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
  localparam logic [6:0] F7_MRET   = 7'b0011000;
  localparam logic [4:0] RS2_MRET  = 5'b00010;
  localparam logic [6:0] F7_ECALL  = 7'b0000000;
  localparam logic [4:0] RS2_ECALL = 5'b00000;
  localparam logic [6:0] F7_EBREAK = 7'b0000000;
  localparam logic [4:0] RS2_EBREAK = 5'b00001;
  localparam logic [6:0] F7_WFI    = 7'b0001000;
  localparam logic [4:0] RS2_WFI   = 5'b00101;

  // Vectored mode jumps to base + 4*cause.
  function automatic logic [6:0] vec_offset(input logic [3:0] cause);
    return {1'b0, cause, 2'b00};
  endfunction

endpackage

// File: rtl/msrv32_irq_prio_enc.sv
// Fixed-priority encoder for external IRQ lines: lowest set index wins; purely combinational, no flow control.
module msrv32_irq_prio_enc #(
  parameter int NUM_EXT_IRQ = 8,
  parameter int EXT_ID_W    = 4
) (
  input  logic [NUM_EXT_IRQ-1:0] req_in,
  output logic                   vld_out,
  output logic [EXT_ID_W-1:0]    id_out
);

  always_comb begin
    vld_out = 1'b0;
    id_out  = '0;
    // Scan downwards so the lowest active index is the last assignment.
    for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
      if (req_in[i]) begin
        vld_out = 1'b1;
        id_out  = EXT_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap/return sequencer: one-cycle trap entry/return states, cause latched on entry edge; no backpressure.
// Optional wfi sleep state enabled by MSRV32_TRAP_WFI_EN.
module msrv32_trap_controller
  import msrv32_trap_pkg::*;
#(
  parameter int NUM_EXT_IRQ = 8,
  parameter int EXT_ID_W    = 4
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic                   illegal_instr_in,
  input  logic                   misaligned_load_in,
  input  logic                   misaligned_store_in,
  input  logic                   misaligned_instr_in,
  input  logic [4:0]             opcode_6_to_2_in,
  input  logic [2:0]             funct3_in,
  input  logic [6:0]             funct7_in,
  input  logic [4:0]             rs1_addr_in,
  input  logic [4:0]             rs2_addr_in,
  input  logic [4:0]             rd_addr_in,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq_in,
  input  logic [NUM_EXT_IRQ-1:0] ext_irq_en_in,
  input  logic                   t_irq_in,
  input  logic                   s_irq_in,
  input  logic                   mie_in,
  input  logic                   meie_in,
  input  logic                   mtie_in,
  input  logic                   msie_in,
  input  logic                   meip_in,
  input  logic                   mtip_in,
  input  logic                   msip_in,
  input  logic                   mtvec_mode_in,
  output logic                   i_or_e_out,
  output logic [3:0]             cause_out,
  output logic [EXT_ID_W-1:0]    ext_irq_id_out,
  output logic [6:0]             trap_vec_offset_out,
  output logic                   set_epc_out,
  output logic                   set_cause_out,
  output logic                   mie_clear_out,
  output logic                   mie_set_out,
  output logic                   instret_inc_out,
  output logic                   misaligned_exception_out,
  output logic [1:0]             pc_src_out,
  output logic                   flush_out,
  output logic                   trap_taken_out
);

  state_t                state_q, state_d;
  logic [3:0]            cause_q, cause_d;
  logic                  i_or_e_q, i_or_e_d;
  logic [EXT_ID_W-1:0]   ext_id_q, ext_id_d;
  logic [6:0]            offset_q, offset_d;
  logic                  misalign_q, misalign_d;

  logic                  is_system, fields_zero;
  logic                  mret, ecall, ebreak, wfi;
  logic                  ext_vld;
  logic [EXT_ID_W-1:0]   ext_id;
  logic                  eip, tip, sip, irq_any, irq_take, any_exc;
  logic [3:0]            cause_new;
  logic                  i_or_e_new;

  msrv32_irq_prio_enc #(
    .NUM_EXT_IRQ (NUM_EXT_IRQ),
    .EXT_ID_W    (EXT_ID_W)
  ) u_prio_enc (
    .req_in  (ext_irq_in & ext_irq_en_in),
    .vld_out (ext_vld),
    .id_out  (ext_id)
  );

  assign is_system   = (opcode_6_to_2_in == OPCODE_SYSTEM);
  assign fields_zero = (funct3_in == 3'b000) && (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
  assign mret   = is_system && fields_zero && (funct7_in == F7_MRET)   && (rs2_addr_in == RS2_MRET);
  assign ecall  = is_system && fields_zero && (funct7_in == F7_ECALL)  && (rs2_addr_in == RS2_ECALL);
  assign ebreak = is_system && fields_zero && (funct7_in == F7_EBREAK) && (rs2_addr_in == RS2_EBREAK);
`ifdef MSRV32_TRAP_WFI_EN
  assign wfi    = is_system && fields_zero && (funct7_in == F7_WFI)    && (rs2_addr_in == RS2_WFI);
`else
  assign wfi    = 1'b0;
`endif

  assign eip      = meie_in & (ext_vld | meip_in);
  assign tip      = mtie_in & (t_irq_in | mtip_in);
  assign sip      = msie_in & (s_irq_in | msip_in);
  assign irq_any  = eip | sip | tip;
  assign irq_take = mie_in & irq_any;
  assign any_exc  = illegal_instr_in | misaligned_instr_in | misaligned_load_in | misaligned_store_in;
  assign trap_taken_out = irq_take | any_exc | ecall | ebreak;

  always_comb begin
    cause_new  = CAUSE_LOAD_MISALIGN;
    i_or_e_new = 1'b0;
    if (irq_take && eip) begin
      cause_new = CAUSE_M_EXT_IRQ; i_or_e_new = 1'b1;
    end else if (irq_take && sip) begin
      cause_new = CAUSE_M_SW_IRQ; i_or_e_new = 1'b1;
    end else if (irq_take && tip) begin
      cause_new = CAUSE_M_TIMER_IRQ; i_or_e_new = 1'b1;
    end else if (illegal_instr_in) cause_new = CAUSE_ILLEGAL_INSTR;
    else if (misaligned_instr_in)  cause_new = CAUSE_INSTR_MISALIGN;
    else if (ecall)                cause_new = CAUSE_ECALL_M;
    else if (ebreak)               cause_new = CAUSE_BREAKPOINT;
    else if (misaligned_store_in)  cause_new = CAUSE_STORE_MISALIGN;
  end

  // Capture only when actually leaving OPERATING for TRAP_TAKEN; held in every other cycle.
  always_comb begin
    cause_d    = cause_q;
    i_or_e_d   = i_or_e_q;
    ext_id_d   = ext_id_q;
    offset_d   = offset_q;
    misalign_d = misaligned_load_in | misaligned_store_in | misaligned_instr_in;
    if (state_q == OPERATING && trap_taken_out) begin
      cause_d  = cause_new;
      i_or_e_d = i_or_e_new;
      offset_d = (i_or_e_new && mtvec_mode_in) ? vec_offset(cause_new) : 7'd0;
      if (irq_take && eip) ext_id_d = ext_vld ? ext_id : '0;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_src_out      = PC_BOOT;
    flush_out       = 1'b0;
    set_epc_out     = 1'b0;
    set_cause_out   = 1'b0;
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    instret_inc_out = 1'b0;
    case (state_q)
      RESET: begin
        flush_out = 1'b1;
        state_d   = OPERATING;
      end
      OPERATING: begin
        pc_src_out      = PC_NEXT;
        instret_inc_out = 1'b1;
        if (trap_taken_out) state_d = TRAP_TAKEN;
        else if (mret)      state_d = TRAP_RETURN;
`ifdef MSRV32_TRAP_WFI_EN
        else if (wfi)       state_d = WFI_SLEEP;
`endif
      end
      TRAP_TAKEN: begin
        pc_src_out    = PC_TRAP;
        flush_out     = 1'b1;
        set_epc_out   = 1'b1;
        set_cause_out = 1'b1;
        mie_clear_out = 1'b1;
        state_d       = OPERATING;
      end
      TRAP_RETURN: begin
        pc_src_out  = PC_EPC;
        flush_out   = 1'b1;
        mie_set_out = 1'b1;
        state_d     = OPERATING;
      end
`ifdef MSRV32_TRAP_WFI_EN
      WFI_SLEEP: begin
        // Wake ignores the global enable; the trap, if any, follows from OPERATING.
        pc_src_out = PC_NEXT;
        if (irq_any) state_d = OPERATING;
      end
`endif
      default: state_d = RESET;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= RESET;
      cause_q    <= 4'd0;
      i_or_e_q   <= 1'b0;
      ext_id_q   <= '0;
      offset_q   <= 7'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      i_or_e_q   <= i_or_e_d;
      ext_id_q   <= ext_id_d;
      offset_q   <= offset_d;
      misalign_q <= misalign_d;
    end
  end

  assign cause_out                = cause_q;
  assign i_or_e_out               = i_or_e_q;
  assign ext_irq_id_out           = ext_id_q;
  assign trap_vec_offset_out      = offset_q;
  assign misaligned_exception_out = misalign_q;

endmodule

// File: tb/tb_msrv32_trap_controller.sv
// Directed-vector bench for msrv32_trap_controller; covers the wfi sleep path when MSRV32_TRAP_WFI_EN is defined.
module tb_msrv32_trap_controller;

  logic       clk_in = 1'b0;
  logic       reset_n_in;
  logic       illegal_instr_in, misaligned_load_in, misaligned_store_in, misaligned_instr_in;
  logic [4:0] opcode_6_to_2_in;
  logic [2:0] funct3_in;
  logic [6:0] funct7_in;
  logic [4:0] rs1_addr_in, rs2_addr_in, rd_addr_in;
  logic [7:0] ext_irq_in, ext_irq_en_in;
  logic       t_irq_in, s_irq_in;
  logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
  logic       mtvec_mode_in;
  logic       i_or_e_out;
  logic [3:0] cause_out;
  logic [3:0] ext_irq_id_out;
  logic [6:0] trap_vec_offset_out;
  logic       set_epc_out, set_cause_out, mie_clear_out, mie_set_out, instret_inc_out;
  logic       misaligned_exception_out;
  logic [1:0] pc_src_out;
  logic       flush_out, trap_taken_out;

  int n_cmp = 0;
  int n_err = 0;

  msrv32_trap_controller #(.NUM_EXT_IRQ(8), .EXT_ID_W(4)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .illegal_instr_in(illegal_instr_in), .misaligned_load_in(misaligned_load_in),
    .misaligned_store_in(misaligned_store_in), .misaligned_instr_in(misaligned_instr_in),
    .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .funct7_in(funct7_in),
    .rs1_addr_in(rs1_addr_in), .rs2_addr_in(rs2_addr_in), .rd_addr_in(rd_addr_in),
    .ext_irq_in(ext_irq_in), .ext_irq_en_in(ext_irq_en_in),
    .t_irq_in(t_irq_in), .s_irq_in(s_irq_in),
    .mie_in(mie_in), .meie_in(meie_in), .mtie_in(mtie_in), .msie_in(msie_in),
    .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .mtvec_mode_in(mtvec_mode_in),
    .i_or_e_out(i_or_e_out), .cause_out(cause_out), .ext_irq_id_out(ext_irq_id_out),
    .trap_vec_offset_out(trap_vec_offset_out),
    .set_epc_out(set_epc_out), .set_cause_out(set_cause_out),
    .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .instret_inc_out(instret_inc_out), .misaligned_exception_out(misaligned_exception_out),
    .pc_src_out(pc_src_out), .flush_out(flush_out), .trap_taken_out(trap_taken_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic clr();
    illegal_instr_in = 0; misaligned_load_in = 0; misaligned_store_in = 0; misaligned_instr_in = 0;
    opcode_6_to_2_in = 5'b01100; funct3_in = 0; funct7_in = 0;
    rs1_addr_in = 0; rs2_addr_in = 0; rd_addr_in = 0;
    ext_irq_in = 0; ext_irq_en_in = 0; t_irq_in = 0; s_irq_in = 0;
    mie_in = 0; meie_in = 0; mtie_in = 0; msie_in = 0; meip_in = 0; mtip_in = 0; msip_in = 0;
    mtvec_mode_in = 0;
  endtask

  task automatic sys(input logic [6:0] f7, input logic [4:0] rs2);
    opcode_6_to_2_in = 5'b11100; funct7_in = f7; rs2_addr_in = rs2;
    funct3_in = 0; rs1_addr_in = 0; rd_addr_in = 0;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    clr();
    reset_n_in = 1'b0;
    #12;
    chk("rst_pc_src", pc_src_out, 2'b00);
    chk("rst_flush", flush_out, 1);
    chk("rst_cause", cause_out, 0);
    chk("rst_ioe", i_or_e_out, 0);
    chk("rst_ext_id", ext_irq_id_out, 0);
    chk("rst_offset", trap_vec_offset_out, 0);
    chk("rst_misalign", misaligned_exception_out, 0);
    chk("rst_instret", instret_inc_out, 0);
    reset_n_in = 1'b1;
    #1;
    chk("rel_pc_boot", pc_src_out, 2'b00);
    step();
    chk("op_pc_next", pc_src_out, 2'b11);
    chk("op_instret", instret_inc_out, 1);
    chk("op_flush", flush_out, 0);

    // External interrupt, lines 3 and 5, vectored
    ext_irq_in = 8'b0010_1000; ext_irq_en_in = 8'hFF; meie_in = 1; mie_in = 1; mtvec_mode_in = 1;
    #1;
    chk("ext_trap_req", trap_taken_out, 1);
    step();
    clr();
    chk("ext_pc_trap", pc_src_out, 2'b10);
    chk("ext_set_epc", set_epc_out, 1);
    chk("ext_set_cause", set_cause_out, 1);
    chk("ext_mie_clear", mie_clear_out, 1);
    chk("ext_flush", flush_out, 1);
    chk("ext_cause", cause_out, 4'b1011);
    chk("ext_ioe", i_or_e_out, 1);
    chk("ext_id", ext_irq_id_out, 3);
    chk("ext_offset", trap_vec_offset_out, 44);
    step();
    chk("ext_back_op", pc_src_out, 2'b11);
    chk("ext_cause_held", cause_out, 4'b1011);

    // illegal + ecall together, vectored mode but exception
    illegal_instr_in = 1; sys(7'b0, 5'b00000); mtvec_mode_in = 1;
    step();
    clr();
    chk("ill_cause", cause_out, 4'b0010);
    chk("ill_ioe", i_or_e_out, 0);
    chk("ill_offset", trap_vec_offset_out, 0);
    chk("ill_ext_id_kept", ext_irq_id_out, 3);
    step();

    // mret with mie=0
    sys(7'b0011000, 5'b00010);
    #1;
    chk("mret_no_trap", trap_taken_out, 0);
    step();
    clr();
    chk("mret_pc_epc", pc_src_out, 2'b01);
    chk("mret_mie_set", mie_set_out, 1);
    chk("mret_flush", flush_out, 1);
    chk("mret_no_epc", set_epc_out, 0);
    step();
    chk("mret_back_op", pc_src_out, 2'b11);

    // Masked timer, then enable; cause must hold after entry
    t_irq_in = 1; mtie_in = 1; mie_in = 0; mtvec_mode_in = 1;
    #1;
    chk("masked_no_req", trap_taken_out, 0);
    step();
    chk("masked_stay_op", pc_src_out, 2'b11);
    chk("masked_cause_held", cause_out, 4'b0010);
    mie_in = 1;
    #1;
    chk("tmr_req", trap_taken_out, 1);
    step();
    chk("tmr_pc_trap", pc_src_out, 2'b10);
    chk("tmr_cause", cause_out, 4'b0111);
    chk("tmr_ioe", i_or_e_out, 1);
    chk("tmr_offset", trap_vec_offset_out, 28);
    // New request during TRAP_TAKEN must not re-latch
    clr(); illegal_instr_in = 1; mtvec_mode_in = 0;
    step();
    clr();
    chk("tmr_cause_hold", cause_out, 4'b0111);
    chk("tmr_offset_hold", trap_vec_offset_out, 28);
    chk("tmr_hold_op", pc_src_out, 2'b11);
    step();

    // Load misaligned: registered flag and lowest-priority cause
    misaligned_load_in = 1;
    step();
    clr();
    chk("ld_mis_flag", misaligned_exception_out, 1);
    chk("ld_mis_cause", cause_out, 4'b0100);
    step();
    chk("ld_mis_flag_clr", misaligned_exception_out, 0);

    // meip only: id forced to 0
    meie_in = 1; meip_in = 1; mie_in = 1;
    step();
    clr();
    chk("meip_cause", cause_out, 4'b1011);
    chk("meip_id", ext_irq_id_out, 0);
    step();

    // Enable mask + ext beats software
    ext_irq_in = 8'b1000_0011; ext_irq_en_in = 8'b1000_0010; meie_in = 1; mie_in = 1;
    s_irq_in = 1; msie_in = 1;
    step();
    clr();
    chk("mask_cause", cause_out, 4'b1011);
    chk("mask_id", ext_irq_id_out, 1);
    step();

    // Software beats timer
    s_irq_in = 1; msie_in = 1; mtip_in = 1; mtie_in = 1; mie_in = 1;
    step();
    clr();
    chk("sw_cause", cause_out, 4'b0011);
    chk("sw_ioe", i_or_e_out, 1);
    chk("sw_id_kept", ext_irq_id_out, 1);
    step();

    // ebreak beats store misaligned
    sys(7'b0, 5'b00001); misaligned_store_in = 1;
    step();
    clr();
    chk("ebrk_cause", cause_out, 4'b0011);
    chk("ebrk_ioe", i_or_e_out, 0);
    step();

    // instr misaligned beats store misaligned
    misaligned_instr_in = 1; misaligned_store_in = 1;
    step();
    clr();
    chk("imis_cause", cause_out, 4'b0000);
    step();

`ifdef MSRV32_TRAP_WFI_EN
    sys(7'b0001000, 5'b00101);
    #1;
    chk("wfi_no_req", trap_taken_out, 0);
    step();
    clr();
    chk("wfi_instret", instret_inc_out, 0);
    chk("wfi_pc", pc_src_out, 2'b11);
    chk("wfi_flush", flush_out, 0);
    step();
    chk("wfi_still", instret_inc_out, 0);
    t_irq_in = 1; mtie_in = 1; mie_in = 0;
    step();
    chk("wfi_wake", instret_inc_out, 1);
    step();
    clr();
    chk("wfi_no_trap", set_epc_out, 0);
    chk("wfi_op", pc_src_out, 2'b11);
`endif

    // Reset in the middle of a trap
    illegal_instr_in = 1;
    step();
    clr();
    chk("mid_set_epc", set_epc_out, 1);
    #2;
    reset_n_in = 1'b0;
    #1;
    chk("mid_rst_epc", set_epc_out, 0);
    chk("mid_rst_cause_pulse", set_cause_out, 0);
    chk("mid_rst_pc", pc_src_out, 2'b00);
    chk("mid_rst_cause", cause_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/msrv32_trap_controller.md
Name: msrv32_trap_controller

Overview:
- Next-generation machine-mode trap/return sequencer for the msrv32 core.
- Adds a parametrised external-interrupt bank with fixed-priority ID encoding and a vectored-trap offset output.
- Corrects cause capture so cause is latched only on the trap-entry edge.
- Sits between control unit, pipeline stage 1/2 registers, CSR file and PC mux.

Parameters:
- NUM_EXT_IRQ, 8: number of platform external interrupt lines; legal range 1..16.
- EXT_ID_W, 4: width of the external IRQ ID output; must satisfy 2**EXT_ID_W >= NUM_EXT_IRQ.

Ports:
- clk_in  in  1  core clock
- reset_n_in  in  1  asynchronous active-low reset
- illegal_instr_in, misaligned_load_in, misaligned_store_in  in  1 each  exceptions from control unit
- misaligned_instr_in  in  1  from pipeline stage 1
- opcode_6_to_2_in  in  5  instruction opcode bits [6:2]
- funct3_in  in  3  instruction field
- funct7_in  in  7  instruction field
- rs1_addr_in, rs2_addr_in, rd_addr_in  in  5 each  instruction fields
- ext_irq_in  in  NUM_EXT_IRQ  level-sensitive platform IRQ lines
- ext_irq_en_in  in  NUM_EXT_IRQ  per-line enable (CSR-backed)
- t_irq_in, s_irq_in  in  1 each  timer/software IRQ
- mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in  in  1 each  CSR state
- mtvec_mode_in  in  1  0=direct, 1=vectored
- i_or_e_out  out  1  1=interrupt, 0=exception
- cause_out  out  4  latched cause code
- ext_irq_id_out  out  EXT_ID_W  latched winning external line index
- trap_vec_offset_out  out  7  cause_out*4 if vectored interrupt, else 0
- set_epc_out, set_cause_out, mie_clear_out, mie_set_out, instret_inc_out  out  1 each  CSR controls
- misaligned_exception_out  out  1  registered OR of the three misaligned inputs
- pc_src_out  out  2  00 BOOT, 01 EPC, 10 TRAP, 11 NEXT
- flush_out  out  1  flush stage-2 register
- trap_taken_out  out  1  combinational trap request to control unit

Behaviour:
- Decode (combinational):
  - system opcode = 11100.
  - mret/ecall/ebreak decoded from rs2 (00010/00000/00001), funct7 (0011000/0/0), with funct3, rs1 and rd all zero.
- Interrupt pending terms:
  - ext_pend = |(ext_irq_in & ext_irq_en_in); eip = meie_in & (ext_pend | meip_in).
  - tip = mtie_in & (t_irq_in | mtip_in); sip = msie_in & (s_irq_in | msip_in).
- trap_taken_out = (mie_in & (eip|sip|tip)) | any exception | ecall | ebreak.
- FSM states, one-hot: RESET, OPERATING, TRAP_TAKEN, TRAP_RETURN.
  - RESET -> OPERATING.
  - OPERATING -> TRAP_TAKEN if trap_taken_out; else TRAP_RETURN if mret; else stay. Trap beats mret when both occur.
  - TRAP_TAKEN and TRAP_RETURN -> OPERATING unconditionally.
- Moore outputs:
  - RESET: BOOT, flush=1, all other controls 0.
  - OPERATING: NEXT, instret_inc=1, others 0.
  - TRAP_TAKEN: TRAP, flush, set_epc, set_cause, mie_clear.
  - TRAP_RETURN: EPC, flush, mie_set.
- Cause latch:
  - Updates only on the edge OPERATING -> TRAP_TAKEN, so cause is valid during TRAP_TAKEN (1-cycle latency from request). Held otherwise.
  - Priority: ext 1011, sw 0011, timer 0111 (interrupts, i_or_e=1); then illegal 0010, instr-misaligned 0000, ecall 1011, ebreak 0011, store-misaligned 0110, load-misaligned 0100 (i_or_e=0).
- ext_irq_id_out:
  - Lowest-index enabled pending line, latched with cause when an external interrupt wins.
  - Set to 0 if only meip_in caused it; unchanged for other causes.
- trap_vec_offset_out: registered with cause.
- Reset: async assert -> state RESET; cause_out, i_or_e_out, ext_irq_id_out, trap_vec_offset_out and misaligned_exception_out all 0. Reset mid-trap abandons the trap with no CSR pulses.
- Unused ext lines: an index >= NUM_EXT_IRQ is never produced.

Optional Feature:
- Macro MSRV32_TRAP_WFI_EN.
- Enabled:
  - Decodes wfi (funct7 0001000, rs2 00101) and adds state WFI_SLEEP, entered from OPERATING when wfi is seen with no trap pending.
  - In WFI_SLEEP: pc_src=NEXT, instret_inc=0, flush=0. Exit to OPERATING when (eip|sip|tip) is nonzero, even if mie_in=0.
  - A trap in the same cycle as wfi wins.
- Disabled: wfi is not decoded and the state is absent.

Decomposition:
- Package msrv32_trap_pkg:
  - State encodings.
  - PC_BOOT/EPC/TRAP/NEXT.
  - Cause code constants.
  - SYSTEM opcode constant.
  - funct7/rs2 patterns for mret, ebreak and wfi.
- Sub-module msrv32_irq_prio_enc: parametrised NUM_EXT_IRQ lowest-index priority encoder, output valid plus id.

Test Plan:
- Reset release: reset_n_in low then high -> one RESET cycle (pc_src=00, flush=1), then OPERATING (pc_src=11, instret_inc=1).
- ext_irq_in=8'b0010_1000, enables all set, meie=mie=1 -> next cycle TRAP_TAKEN, cause=1011, i_or_e=1, ext_irq_id=3; with mtvec_mode=1, offset=44.
- Simultaneous illegal_instr_in and ecall -> cause=0010, i_or_e=0, offset=0.
- mret while mie_in=0 and no exception -> TRAP_RETURN: pc_src=01, mie_set=1, flush=1; then OPERATING.
- Pending interrupt with mie_in=0 -> no trap. Then raise mie_in -> trap taken next cycle, cause latched only on the entry edge and held afterwards.
- With MSRV32_TRAP_WFI_EN: wfi -> WFI_SLEEP, instret_inc=0. Assert t_irq_in with mtie=1, mie=0 -> returns to OPERATING without trapping.
